mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Initiator side of the 256x8 data memory. Sits in the MEM stage of the 8-bit pipeline.
//  Accepts load/store/push/pop requests over a valid/ready handshake and owns the stack pointer.
//  Drives the memory's WE/RE/A/WD pins and returns load/pop data with a 1-cycle rsp_valid pulse.
// PARAMETERS
//  AW        8      address width (memory depth 2**AW)
//  DW        8      data width
//  SP_RESET  8'hFF  stack pointer value after reset
//  SP_LIMIT  8'h80  lowest legal SP; used only with STACK_GUARD_EN
// PORTS
//  Clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  req_valid  in   1   request present
//  req_ready  out  1   controller can accept; high only in IDLE
//  req_op     in   3   0 NOP, 1 LOAD, 2 STORE, 3 PUSH, 4 POP; 5-7 reserved
//  req_addr   in   AW  LOAD/STORE address; ignored for PUSH/POP
//  req_wdata  in   DW  STORE/PUSH data
//  rsp_valid  out  1   one-cycle pulse; rsp_data holds LOAD/POP result
//  rsp_data   out  DW  read result, held until the next response
//  mem_we     out  1   to memory WE
//  mem_re     out  1   to memory RE
//  mem_a      out  AW  to memory A
//  mem_wd     out  DW  to memory WD
//  mem_rd     in   DW  from memory RD; updated at the edge that samples RE
//  sp         out  AW  current stack pointer
//  stack_err  out  1   sticky guard error (tied 0 without STACK_GUARD_EN)
// BEHAVIOUR
//  - Reset: async, overrides everything. State IDLE, sp=SP_RESET, stack_err=0.
//    All other outputs 0 except req_ready=1. An in-flight op is discarded; memory contents are not touched.
//  - All mem_* and rsp_* outputs are registered. req_ready is decoded from state.
//  - Accept = req_valid & req_ready at edge E0. While busy, requests are not accepted;
//    the requester holds req_* stable.
//  - FSM states:
//    - IDLE: on accept of LOAD/POP -> RD_ISSUE; on accept of STORE/PUSH -> WR_ISSUE;
//      NOP/reserved ops are accepted and stay IDLE with no memory activity.
//    - WR_ISSUE: mem_we=1, mem_a/mem_wd valid for one cycle; memory writes at E1. Next state is IDLE.
//    - RD_ISSUE: mem_re=1, mem_a valid for one cycle; memory captures RD at E1. Next state is RD_CAP.
//    - RD_CAP: at E2, rsp_data<=mem_rd and rsp_valid<=1 (high in the cycle after E2). Next state is IDLE.
//  - Latency: LOAD/POP take accept-edge to rsp_valid = 2 edges. Back-to-back throughput is 1 per 3 cycles.
//    STORE/PUSH take 1 per 2 cycles. Response has no backpressure.
//  - Stack is full-descending:
//    - PUSH: mem_a=sp, then sp<=sp-1 at E0.
//    - POP: sp<=sp+1 at E0, then mem_a=sp+1.
//    - Arithmetic is modulo 2**AW, so 8'h00 minus 1 gives 8'hFF and 8'hFF plus 1 gives 8'h00.
//  - mem_we and mem_re are never high in the same cycle. Both are 0 in IDLE and RD_CAP.
// CONFIGURATION
//  STACK_GUARD_EN defined:
//    - PUSH with sp==SP_LIMIT, or POP with sp==SP_RESET: request accepted, no memory access,
//      sp unchanged, stack_err<=1 (sticky until reset). A POP error still pulses rsp_valid with rsp_data=0.
//  STACK_GUARD_EN undefined:
//    - No checks; sp wraps silently; stack_err tied 0.
// STRUCTURE
//  Package mem_ctrl_pkg:
//    - op encodings OP_NOP..OP_POP
//    - FSM state encoding IDLE/WR_ISSUE/RD_ISSUE/RD_CAP
//    - SP_RESET default
//  Sub-module stack_ptr:
//    - SP register with inc/dec and the guard compare
//    - outputs sp, next_sp and an err strobe
//  The FSM and output registers stay in mem_access_ctrl.
// TESTING
//  Bench pairs the controller with the real 256x8 data memory.
//  1. STORE addr 8'h10 data 8'hA5, then LOAD 8'h10 -> rsp_valid 2 edges after accept, rsp_data=8'hA5.
//  2. After reset, PUSH 8'h11 then PUSH 8'h22 -> mem[FF]=11, mem[FE]=22, sp=8'hFD.
//     POP, POP -> rsp_data 22 then 11, sp=8'hFF.
//  3. req_valid held high during RD_ISSUE/RD_CAP -> req_ready=0, no second access;
//     the request is accepted on the IDLE cycle.
//  4. rst_n low in RD_ISSUE -> outputs 0 immediately, no rsp_valid. After release, req_ready=1 and sp=8'hFF.
//  5. Without guard: POP at sp=8'hFF -> sp=8'h00, reads mem[00].
//     With STACK_GUARD_EN: stack_err=1, sp stays 8'hFF, no mem_re.
//  6. Op 3'd6 and NOP -> accepted, zero mem_we/mem_re cycles, no rsp_valid.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the MEM-stage data-memory controller: op codes, FSM states, stack defaults.
package mem_ctrl_pkg;

    localparam int unsigned AW_DEF  = 8;
    localparam int unsigned DW_DEF  = 8;
    localparam int unsigned OPW     = 3;
    localparam int unsigned STW     = 2;

    localparam logic [OPW-1:0] OP_NOP   = 3'd0;
    localparam logic [OPW-1:0] OP_LOAD  = 3'd1;
    localparam logic [OPW-1:0] OP_STORE = 3'd2;
    localparam logic [OPW-1:0] OP_PUSH  = 3'd3;
    localparam logic [OPW-1:0] OP_POP   = 3'd4;

    localparam logic [STW-1:0] IDLE     = 2'd0;
    localparam logic [STW-1:0] WR_ISSUE = 2'd1;
    localparam logic [STW-1:0] RD_ISSUE = 2'd2;
    localparam logic [STW-1:0] RD_CAP   = 2'd3;

    localparam logic [7:0] SP_RESET_DEF = 8'hFF;
    localparam logic [7:0] SP_LIMIT_DEF = 8'h80;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake plus data-memory pins of the MEM-stage controller.
interface mem_access_ctrl_if
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
);
    logic           req_valid;
    logic           req_ready;
    logic [OPW-1:0] req_op;
    logic [AW-1:0]  req_addr;
    logic [DW-1:0]  req_wdata;
    logic           rsp_valid;
    logic [DW-1:0]  rsp_data;
    logic           mem_we;
    logic           mem_re;
    logic [AW-1:0]  mem_a;
    logic [DW-1:0]  mem_wd;
    logic [DW-1:0]  mem_rd;
    logic [AW-1:0]  sp;
    logic           stack_err;

    // Controller side
    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, mem_rd,
        output req_ready, rsp_valid, rsp_data, mem_we, mem_re, mem_a, mem_wd, sp, stack_err
    );

    // Requester and memory side
    modport master (
        output req_valid, req_op, req_addr, req_wdata, mem_rd,
        input  req_ready, rsp_valid, rsp_data, mem_we, mem_re, mem_a, mem_wd, sp, stack_err
    );
endinterface

// File: rtl/mem_access_ctrl_stack_ptr.sv
// Full-descending stack pointer with modulo inc/dec; bounds guard enabled by STACK_GUARD_EN.
module stack_ptr #(
    parameter int unsigned    AW       = 8,
    parameter logic [AW-1:0]  SP_RESET = AW'(8'hFF),
    parameter logic [AW-1:0]  SP_LIMIT = AW'(8'h80)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    output logic [AW-1:0] sp_o,
    output logic [AW-1:0] next_sp_c_o,
    output logic          err_c_o
);
`ifdef STACK_GUARD_EN
    localparam logic GUARD = 1'b1;
`else
    localparam logic GUARD = 1'b0;
`endif

    logic [AW-1:0] sp_q, sp_d;

    // A guarded push/pop leaves the pointer where it is
    always_comb begin
        err_c_o = GUARD & ((push_i & (sp_q == SP_LIMIT)) | (pop_i & (sp_q == SP_RESET)));
        sp_d    = sp_q;
        if (!err_c_o) begin
            if (push_i)     sp_d = sp_q - AW'(1);
            else if (pop_i) sp_d = sp_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sp_q <= SP_RESET;
        else        sp_q <= sp_d;
    end

    assign sp_o        = sp_q;
    assign next_sp_c_o = sp_d;

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage initiator for the 256x8 data memory: load/store/push/pop over valid/ready.
// Optional stack bounds checking is compiled in with STACK_GUARD_EN.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned   AW       = AW_DEF,
    parameter int unsigned   DW       = DW_DEF,
    parameter logic [AW-1:0] SP_RESET = AW'(SP_RESET_DEF),
    parameter logic [AW-1:0] SP_LIMIT = AW'(SP_LIMIT_DEF)
) (
    input logic              clk,
    input logic              rst_n,
    mem_access_ctrl_if.slave bus
);

    logic [STW-1:0] state_q, state_d;
    logic           accept_c, push_c, pop_c, err_c;
    logic [AW-1:0]  sp, next_sp_c;
    logic           mem_we_q, mem_we_d;
    logic           mem_re_q, mem_re_d;
    logic [AW-1:0]  mem_a_q, mem_a_d;
    logic [DW-1:0]  mem_wd_q, mem_wd_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]  rsp_data_q, rsp_data_d;

    assign bus.req_ready = (state_q == IDLE);
    assign accept_c      = bus.req_valid & bus.req_ready;
    assign push_c        = accept_c & (bus.req_op == OP_PUSH);
    assign pop_c         = accept_c & (bus.req_op == OP_POP);

    stack_ptr #(
        .AW       (AW),
        .SP_RESET (SP_RESET),
        .SP_LIMIT (SP_LIMIT)
    ) u_stack_ptr (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push_c),
        .pop_i       (pop_c),
        .sp_o        (sp),
        .next_sp_c_o (next_sp_c),
        .err_c_o     (err_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_a_q     <= '0;
            mem_wd_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            mem_a_q     <= mem_a_d;
            mem_wd_q    <= mem_wd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Output registers are loaded with the values the next state must present
    always_comb begin
        state_d     = state_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        mem_a_d     = mem_a_q;
        mem_wd_d    = mem_wd_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    case (bus.req_op)
                        OP_LOAD: begin
                            state_d  = RD_ISSUE;
                            mem_re_d = 1'b1;
                            mem_a_d  = bus.req_addr;
                        end
                        OP_STORE: begin
                            state_d  = WR_ISSUE;
                            mem_we_d = 1'b1;
                            mem_a_d  = bus.req_addr;
                            mem_wd_d = bus.req_wdata;
                        end
                        OP_PUSH: begin
                            if (!err_c) begin
                                state_d  = WR_ISSUE;
                                mem_we_d = 1'b1;
                                mem_a_d  = sp;
                                mem_wd_d = bus.req_wdata;
                            end
                        end
                        OP_POP: begin
                            if (!err_c) begin
                                state_d  = RD_ISSUE;
                                mem_re_d = 1'b1;
                                mem_a_d  = next_sp_c;
                            end else begin
                                rsp_valid_d = 1'b1;
                                rsp_data_d  = '0;
                            end
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
            WR_ISSUE: state_d = IDLE;
            RD_ISSUE: state_d = RD_CAP;
            RD_CAP: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_data_d  = bus.mem_rd;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef STACK_GUARD_EN
    logic stack_err_q;

    // Sticky until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stack_err_q <= 1'b0;
        else        stack_err_q <= stack_err_q | err_c;
    end

    assign bus.stack_err = stack_err_q;
`else
    assign bus.stack_err = 1'b0;
`endif

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_a     = mem_a_q;
    assign bus.mem_wd    = mem_wd_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.sp        = sp;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl paired with a 256x8 synchronous data memory model.
module tb_mem_access_ctrl;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    mem_access_ctrl_if #(.AW(8), .DW(8)) bus ();

    mem_access_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [7:0] mem [256];

    // Data memory: write at the WE edge, RD updated at the edge that samples RE
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_a] <= bus.mem_wd;
        if (bus.mem_re) bus.mem_rd <= mem[bus.mem_a];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one request, then observe four cycles after the accepting edge
    task automatic run_op(input logic [2:0] op, input logic [7:0] addr, input logic [7:0] wdata,
                          output int n_we, output int n_re, output int n_rsp,
                          output int lat, output int ovl, output int acc_ok);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        acc_ok = 0;
        for (int n = 0; n < 20; n++) begin
            if (bus.req_ready) begin
                acc_ok = 1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n_we = 0; n_re = 0; n_rsp = 0; lat = -1; ovl = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            n_we  += int'(bus.mem_we);
            n_re  += int'(bus.mem_re);
            n_rsp += int'(bus.rsp_valid);
            ovl   += int'(bus.mem_we & bus.mem_re);
            if (bus.rsp_valid && lat < 0) lat = i;
        end
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         n_we;
        int         n_re;
        int         n_rsp;
        logic [7:0] rdata;
        logic [7:0] sp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int n_we, n_re, n_rsp, lat, ovl, acc_ok;
        int acc, rdy_after, rsp_cnt;
        errors = 0;
        checks = 0;

        vecs[0] = '{3'd2, 8'h10, 8'hA5, 1, 0, 0, 8'h00, 8'hFF};
        vecs[1] = '{3'd1, 8'h10, 8'h00, 0, 1, 1, 8'hA5, 8'hFF};
        vecs[2] = '{3'd2, 8'h00, 8'h3C, 1, 0, 0, 8'hA5, 8'hFF};
        vecs[3] = '{3'd3, 8'h00, 8'h11, 1, 0, 0, 8'hA5, 8'hFE};
        vecs[4] = '{3'd3, 8'h00, 8'h22, 1, 0, 0, 8'hA5, 8'hFD};
        vecs[5] = '{3'd4, 8'h00, 8'h00, 0, 1, 1, 8'h22, 8'hFE};
        vecs[6] = '{3'd4, 8'h00, 8'h00, 0, 1, 1, 8'h11, 8'hFF};
        vecs[7] = '{3'd0, 8'h10, 8'hEE, 0, 0, 0, 8'h11, 8'hFF};
        vecs[8] = '{3'd6, 8'h10, 8'hEE, 0, 0, 0, 8'h11, 8'hFF};
        vecs[9] = '{3'd7, 8'h20, 8'hEE, 0, 0, 0, 8'h11, 8'hFF};

        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_addr  = 8'h00;
        bus.req_wdata = 8'h00;
        repeat (3) @(negedge clk);

        chk("rst_req_ready", int'(bus.req_ready), 1);
        chk("rst_sp", int'(bus.sp), 8'hFF);
        chk("rst_stack_err", int'(bus.stack_err), 0);
        chk("rst_mem_we", int'(bus.mem_we), 0);
        chk("rst_mem_re", int'(bus.mem_re), 0);
        chk("rst_mem_a", int'(bus.mem_a), 0);
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_rsp_data", int'(bus.rsp_data), 0);
        rst_n = 1'b1;

        for (int v = 0; v < 10; v++) begin
            run_op(vecs[v].op, vecs[v].addr, vecs[v].wdata, n_we, n_re, n_rsp, lat, ovl, acc_ok);
            chk($sformatf("v%0d_accept", v), acc_ok, 1);
            chk($sformatf("v%0d_we_cycles", v), n_we, vecs[v].n_we);
            chk($sformatf("v%0d_re_cycles", v), n_re, vecs[v].n_re);
            chk($sformatf("v%0d_rsp_pulses", v), n_rsp, vecs[v].n_rsp);
            chk($sformatf("v%0d_we_re_overlap", v), ovl, 0);
            chk($sformatf("v%0d_rsp_data", v), int'(bus.rsp_data), int'(vecs[v].rdata));
            chk($sformatf("v%0d_sp", v), int'(bus.sp), int'(vecs[v].sp));
            if (vecs[v].n_rsp != 0) chk($sformatf("v%0d_rsp_latency", v), lat, 2);
        end
        chk("mem_ff_push", int'(mem[8'hFF]), 8'h11);
        chk("mem_fe_push", int'(mem[8'hFE]), 8'h22);
        chk("mem_10_store", int'(mem[8'h10]), 8'hA5);

        // LOAD held valid for six edges: accepted at E0 and again on the IDLE cycle after E2
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd1;
        bus.req_addr  = 8'h10;
        acc = 0; n_re = 0; rsp_cnt = 0; rdy_after = -1;
        for (int k = 0; k < 6; k++) begin
            if (bus.req_ready) acc++;
            @(posedge clk);
            @(negedge clk);
            if (k == 0) rdy_after = int'(bus.req_ready);
            n_re    += int'(bus.mem_re);
            rsp_cnt += int'(bus.rsp_valid);
        end
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("hold_accepts", acc, 2);
        chk("hold_ready_busy", rdy_after, 0);
        chk("hold_re_cycles", n_re, 2);
        chk("hold_rsp_pulses", rsp_cnt, 2);
        chk("hold_rsp_data", int'(bus.rsp_data), 8'hA5);

        // Reset asserted while a LOAD is in RD_ISSUE
        run_op(3'd3, 8'h00, 8'h5A, n_we, n_re, n_rsp, lat, ovl, acc_ok);
        chk("pre_rst_sp", int'(bus.sp), 8'hFE);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd1;
        bus.req_addr  = 8'h10;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("inflight_mem_re", int'(bus.mem_re), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_mem_re", int'(bus.mem_re), 0);
        chk("async_rst_ready", int'(bus.req_ready), 1);
        chk("async_rst_sp", int'(bus.sp), 8'hFF);
        chk("async_rst_mem_a", int'(bus.mem_a), 0);
        rsp_cnt = 0;
        repeat (2) begin
            @(negedge clk);
            rsp_cnt += int'(bus.rsp_valid);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            rsp_cnt += int'(bus.rsp_valid);
        end
        chk("rst_no_rsp", rsp_cnt, 0);
        chk("post_rst_ready", int'(bus.req_ready), 1);
        chk("post_rst_sp", int'(bus.sp), 8'hFF);
        chk("post_rst_rsp_data", int'(bus.rsp_data), 0);

        // POP from an empty stack
        run_op(3'd4, 8'h00, 8'h00, n_we, n_re, n_rsp, lat, ovl, acc_ok);
        chk("empty_pop_accept", acc_ok, 1);
        chk("empty_pop_we", n_we, 0);
`ifdef STACK_GUARD_EN
        chk("guard_pop_re", n_re, 0);
        chk("guard_pop_rsp", n_rsp, 1);
        chk("guard_pop_lat", lat, 0);
        chk("guard_pop_data", int'(bus.rsp_data), 0);
        chk("guard_pop_sp", int'(bus.sp), 8'hFF);
        chk("guard_stack_err", int'(bus.stack_err), 1);
`else
        chk("wrap_pop_re", n_re, 1);
        chk("wrap_pop_rsp", n_rsp, 1);
        chk("wrap_pop_lat", lat, 2);
        chk("wrap_pop_data", int'(bus.rsp_data), 8'h3C);
        chk("wrap_pop_sp", int'(bus.sp), 8'h00);
        run_op(3'd3, 8'h00, 8'h99, n_we, n_re, n_rsp, lat, ovl, acc_ok);
        chk("wrap_push_we", n_we, 1);
        chk("wrap_push_sp", int'(bus.sp), 8'hFF);
        chk("wrap_push_mem00", int'(mem[8'h00]), 8'h99);
        chk("no_guard_stack_err", int'(bus.stack_err), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
